// File: rtl/io_button_regs.sv
// io_button_regs: memory-mapped push-button block for the processor IO space.
//
// Each raw button pin is normalised to active-high and passed through a
// 2-flop synchroniser. A per-button debouncer then accepts a level change
// only after the synchronised value has differed from the accepted level
// for DEBOUNCE_CYCLES consecutive cycles. When a button's debounced level
// goes from released to pressed, a sticky "pressed" flag is set for that
// button. A qualified read returns the flag and the level of the selected
// button, and clears that button's flag at the end of the read cycle.
//
// Ports:
//   clk         system clock (same clock as the processor)
//   rst         synchronous active-high reset
//   btn_raw     raw, asynchronous button pins
//   btn_selecc  button index from the IO address decoder
//   btn_rd_enb  load strobe for the button address range
//   rd_data     combinational read data: {0.., level, flag} of the selected button
//   btn_level   debounced pressed levels (1 = pressed)
//   btn_pending OR of all sticky flags

// Per-button debouncer: RELEASED/PRESSED FSM with a stability counter.
//   clk, rst  clock and synchronous active-high reset
//   sync_i    synchronised, active-high button level
//   deb_o     debounced level (1 = pressed)
//   press_o   one-cycle pulse in the cycle before deb_o rises
module io_button_deb #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic deb_o,
    output logic press_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} deb_state_e;

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only runs while the input disagrees with the accepted
    // level, so any agreement (a glitch ending) restarts the count and the
    // counter can never pass CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RELEASED: begin
                if (sync_i) begin
                    if (cnt_q == CNT_LAST) state_d = PRESSED;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_i) begin
                    if (cnt_q == CNT_LAST) state_d = RELEASED;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign deb_o   = (state_q == PRESSED);
    // Fires while the transition is pending so the sticky flag is set on
    // the same edge the debounced level rises.
    assign press_o = (state_q == RELEASED) && (state_d == PRESSED);
endmodule

module io_button_regs #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_raw,
    input  logic [1:0]        btn_selecc,
    input  logic              btn_rd_enb,
    output logic [DATA_W-1:0] rd_data,
    output logic [N_BTN-1:0]  btn_level,
    output logic              btn_pending
);
    logic [N_BTN-1:0] meta_q, meta_d;
    logic [N_BTN-1:0] sync_q, sync_d;
    logic [N_BTN-1:0] flag_q, flag_d;
    logic [N_BTN-1:0] deb;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            flag_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            flag_q <= flag_d;
        end
    end

    always_comb begin
        meta_d = btn_raw ^ {N_BTN{BTN_ACTIVE_LOW}};
        sync_d = meta_q;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        io_button_deb #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .sync_i (sync_q[i]),
            .deb_o  (deb[i]),
            .press_o(press[i])
        );
    end

    // Set has priority over the read clear so a press landing in the read
    // cycle is not lost.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_BTN; i++) begin
            clr[i] = btn_rd_enb && (int'(btn_selecc) == i);
        end
        flag_d = (flag_q & ~clr) | press;
    end

    // Read returns pre-clear values; the clear lands on the following edge.
    always_comb begin
        rd_data = '0;
        if (btn_rd_enb) begin
            rd_data[0] = flag_q[btn_selecc];
            rd_data[1] = deb[btn_selecc];
        end
    end

    assign btn_level   = deb;
    assign btn_pending = |flag_q;
endmodule

// File: tb/tb_io_button_regs.sv
module tb_io_button_regs;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    btn_raw;
    logic [1:0]    btn_selecc;
    logic          btn_rd_enb;
    logic [DW-1:0] rd_data;
    logic [3:0]    btn_level;
    logic          btn_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        logic [DW-1:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    io_button_regs #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .BTN_ACTIVE_LOW (1'b1),
        .DATA_W         (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_selecc (btn_selecc),
        .btn_rd_enb (btn_rd_enb),
        .rd_data    (rd_data),
        .btn_level  (btn_level),
        .btn_pending(btn_pending)
    );

    // Advance n rising edges; inputs change 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a read and queue its expected data.
    task automatic rd_start(input logic [1:0] sel, input logic [DW-1:0] exp, input string nm);
        exp_t e;
        btn_selecc = sel;
        btn_rd_enb = 1'b1;
        e.name = nm;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; btn_raw = 4'hF; btn_selecc = 2'd0; btn_rd_enb = 1'b0;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_start(2'(i % 4), '0, "reset_idle_rd");
            #4;
            e = sb.pop_front();
            checks++;
            if (rd_data !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, i, rd_data, e.exp);
            end
            checks++;
            if ({btn_level, btn_pending} !== 5'b0) begin
                failures++;
                $display("FAIL reset_idle_state cyc=%0d level=%b pending=%b exp=0", i, btn_level, btn_pending);
            end
            step(1);
        end
        btn_rd_enb = 1'b0;
    endtask

    task automatic test_clean_press();
        exp_t e;
        btn_raw[2] = 1'b0;
        step(5); #4;
        checks++;
        if (btn_level !== 4'b0000) begin
            failures++;
            $display("FAIL clean_level_early got=%b exp=%b", btn_level, 4'b0000);
        end
        step(1); #4;
        checks++;
        if ({btn_level, btn_pending} !== {4'b0100, 1'b1}) begin
            failures++;
            $display("FAIL clean_level_rise level=%b pending=%b exp=0100/1", btn_level, btn_pending);
        end
        step(1);
        rd_start(2'd2, 32'h3, "clean_rd_first");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.exp);
        end
        step(1);
        rd_start(2'd2, 32'h2, "clean_rd_second");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
        btn_raw[2] = 1'b1;
        step(6);
        rd_start(2'd2, 32'h0, "clean_rd_released");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_pending !== 1'b0) begin
            failures++; $display("FAIL %s got=%h pending=%b exp=%h/0", e.name, rd_data, btn_pending, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
    endtask

    task automatic test_glitch();
        exp_t e;
        btn_raw[0] = 1'b0;
        step(3);
        btn_raw[0] = 1'b1;
        step(8);
        rd_start(2'd0, 32'h0, "glitch3_rd");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_level !== 4'b0 || btn_pending !== 1'b0) begin
            failures++;
            $display("FAIL %s got=%h level=%b pending=%b exp=%h/0000/0", e.name, rd_data, btn_level, btn_pending, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
        btn_raw[0] = 1'b0;
        step(5);
        btn_raw[0] = 1'b1;
        step(8);
        rd_start(2'd0, 32'h1, "glitch5_rd");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_pending !== 1'b1) begin
            failures++; $display("FAIL %s got=%h pending=%b exp=%h/1", e.name, rd_data, btn_pending, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
        #4; checks++;
        if (btn_pending !== 1'b0) begin
            failures++; $display("FAIL glitch5_cleared pending=%b exp=0", btn_pending);
        end
    endtask

    task automatic test_collision();
        exp_t e;
        step(1);
        btn_raw[1] = 1'b0;
        step(5);
        rd_start(2'd1, 32'h0, "collide_rd_pulse");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.exp);
        end
        step(1);
        rd_start(2'd1, 32'h3, "collide_rd_next");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_pending !== 1'b1) begin
            failures++; $display("FAIL %s got=%h pending=%b exp=%h/1", e.name, rd_data, btn_pending, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
        btn_raw[1] = 1'b1;
        #4; checks++;
        if (btn_pending !== 1'b0) begin
            failures++; $display("FAIL collide_cleared pending=%b exp=0", btn_pending);
        end
        step(7);
    endtask

    task automatic test_selective();
        exp_t e;
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        step(7);
        rd_start(2'd0, 32'h3, "sel_rd0");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.exp);
        end
        step(1);
        rd_start(2'd3, 32'h3, "sel_rd3");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_pending !== 1'b1 || btn_level !== 4'b1001) begin
            failures++;
            $display("FAIL %s got=%h pending=%b level=%b exp=%h/1/1001", e.name, rd_data, btn_pending, btn_level, e.exp);
        end
        step(1);
        rd_start(2'd0, 32'h2, "sel_rd0_again");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_pending !== 1'b0) begin
            failures++; $display("FAIL %s got=%h pending=%b exp=%h/0", e.name, rd_data, btn_pending, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
        btn_raw = 4'hF;
        step(7);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        btn_raw[2] = 1'b0;
        step(7); #4;
        checks++;
        if ({btn_level, btn_pending} !== {4'b0100, 1'b1}) begin
            failures++; $display("FAIL rstmid_before level=%b pending=%b exp=0100/1", btn_level, btn_pending);
        end
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rd_start(2'd2, 32'h0, "rstmid_rd_after");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp || btn_level !== 4'b0 || btn_pending !== 1'b0) begin
            failures++;
            $display("FAIL %s got=%h level=%b pending=%b exp=%h/0000/0", e.name, rd_data, btn_level, btn_pending, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
        step(4); #4;
        checks++;
        if ({btn_level, btn_pending} !== 5'b0) begin
            failures++; $display("FAIL rstmid_early level=%b pending=%b exp=0000/0", btn_level, btn_pending);
        end
        step(1); #4;
        checks++;
        if ({btn_level, btn_pending} !== {4'b0100, 1'b1}) begin
            failures++; $display("FAIL rstmid_return level=%b pending=%b exp=0100/1", btn_level, btn_pending);
        end
        step(1);
        btn_raw[2] = 1'b1;
        step(7);
        rd_start(2'd2, 32'h1, "rstmid_rd_flag");
        #4; e = sb.pop_front(); checks++;
        if (rd_data !== e.exp) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.exp);
        end
        step(1);
        btn_rd_enb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_collision();
        test_selective();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
